// File: rtl/conv2d_reframe.sv
// conv2d_reframe: requantizes conv2d valid-window results into a full raster with border fill.
// Define CONV2D_REFRAME_MARKERS_EN to add registered sof_o/eol_o sidebands.
module conv2d_reframe #(
  parameter int LineWidthPx = 160,
  parameter int LineCountPx = 120,
  parameter int KernelWidth = 3,
  parameter int WidthIn     = 32,
  parameter int WidthOut    = 2,
  parameter int Shift       = 0,
  parameter logic [WidthOut-1:0] FillValue = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [WidthIn-1:0]  data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [WidthOut-1:0] data_o
`ifdef CONV2D_REFRAME_MARKERS_EN
  ,
  output logic                sof_o,
  output logic                eol_o
`endif
);

  localparam int XW  = $clog2(LineWidthPx > 1 ? LineWidthPx : 2);
  localparam int YW  = $clog2(LineCountPx > 1 ? LineCountPx : 2);
  localparam int Top = (KernelWidth - 1) / 2;
  localparam int InW = LineWidthPx - KernelWidth + 1;
  localparam int InH = LineCountPx - KernelWidth + 1;

  localparam logic [XW-1:0] XLast = XW'(LineWidthPx - 1);
  localparam logic [YW-1:0] YLast = YW'(LineCountPx - 1);

  localparam logic signed [WidthIn-1:0] QMax =
    WidthIn'((1 << WidthOut) - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic [XW:0] x_rel;
  logic [YW:0] y_rel;
  logic        interior;
  logic        slot_free;
  logic        load;

  logic signed [WidthIn-1:0] shifted;
  logic [WidthOut-1:0]       quant;

  // Offset-then-compare covers both region bounds with a single unsigned test.
  assign x_rel = {1'b0, x_q} - (XW+1)'(Top);
  assign y_rel = {1'b0, y_q} - (YW+1)'(Top);

  assign interior = (x_rel < (XW+1)'(InW))
                  & (y_rel < (YW+1)'(InH));

  assign slot_free = ~valid_o | ready_i;
  assign ready_o   = slot_free & interior;
  assign load      = slot_free & (~interior | valid_i);

  assign shifted = $signed(data_i) >>> Shift;

  always_comb begin
    quant = shifted[WidthOut-1:0];
    if (shifted[WidthIn-1]) begin
      quant = '0;
    end else if (shifted > QMax) begin
      quant = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      x_q     <= '0;
      y_q     <= '0;
`ifdef CONV2D_REFRAME_MARKERS_EN
      sof_o   <= 1'b0;
      eol_o   <= 1'b0;
`endif
    end else if (slot_free) begin
      valid_o <= load;
      if (load) begin
        data_o <= interior ? quant : FillValue;
`ifdef CONV2D_REFRAME_MARKERS_EN
        sof_o  <= (x_q == '0) && (y_q == '0);
        eol_o  <= (x_q == XLast);
`endif
        if (x_q == XLast) begin
          x_q <= '0;
          y_q <= (y_q == YLast) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2d_reframe.sv
// tb_conv2d_reframe: directed and randomized checks of conv2d_reframe
// against a raster-order reference model.
module tb_conv2d_reframe;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int K  = 3;
  localparam int WI = 32;
  localparam int WO = 2;
  localparam int N  = W * H;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [WI-1:0] data_i  = '0;
  logic          ready_o, valid_o;
  logic [WO-1:0] data_o;

  logic          q_valid_i = 1'b0;
  logic          q_ready_i = 1'b1;
  logic [WI-1:0] q_data_i  = '0;
  logic          q_ready_o, q_valid_o;
  logic [WO-1:0] q_data_o;

  logic          k_valid_i = 1'b0;
  logic          k_ready_i = 1'b1;
  logic [WI-1:0] k_data_i  = '0;
  logic          k_ready_o, k_valid_o;
  logic [WO-1:0] k_data_o;

`ifdef CONV2D_REFRAME_MARKERS_EN
  logic sof, eol, q_sof, q_eol, k_sof, k_eol;
`endif

  conv2d_reframe #(
    .LineWidthPx(W), .LineCountPx(H), .KernelWidth(K),
    .WidthIn(WI), .WidthOut(WO), .Shift(0), .FillValue('0)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
`ifdef CONV2D_REFRAME_MARKERS_EN
    , .sof_o(sof), .eol_o(eol)
`endif
  );

  conv2d_reframe #(
    .LineWidthPx(W), .LineCountPx(H), .KernelWidth(K),
    .WidthIn(WI), .WidthOut(WO), .Shift(1), .FillValue('0)
  ) u_q (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_i(q_valid_i), .ready_o(q_ready_o), .data_i(q_data_i),
    .valid_o(q_valid_o), .ready_i(q_ready_i), .data_o(q_data_o)
`ifdef CONV2D_REFRAME_MARKERS_EN
    , .sof_o(q_sof), .eol_o(q_eol)
`endif
  );

  conv2d_reframe #(
    .LineWidthPx(W), .LineCountPx(H), .KernelWidth(1),
    .WidthIn(WI), .WidthOut(WO), .Shift(0), .FillValue('0)
  ) u_k1 (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_i(k_valid_i), .ready_o(k_ready_o), .data_i(k_data_i),
    .valid_o(k_valid_o), .ready_i(k_ready_i), .data_o(k_data_o)
`ifdef CONV2D_REFRAME_MARKERS_EN
    , .sof_o(k_sof), .eol_o(k_eol)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int quant(int v, int sh, int wout);
    int s;
    int mx;
    s  = v >>> sh;
    mx = (1 << wout) - 1;
    if (s < 0) return 0;
    if (s > mx) return mx;
    return s;
  endfunction

  function automatic bit interior(int idx, int w, int h, int k);
    int x, y, t, b;
    x = idx % w;
    y = (idx / w) % h;
    t = (k - 1) / 2;
    b = k - 1 - t;
    return (x >= t) && (x <= w - 1 - b) && (y >= t) && (y <= h - 1 - b);
  endfunction

  // Stream nfr frames through u_dut; limit >= 0 stops after that many outputs.
  task automatic run(int nfr, bit rnd, int limit);
    int inq[$];
    int expq[$];
    int k;
    int cyc;
    int total;
    int prev;
    int v;
    bit hold;
    k    = 0;
    cyc  = 0;
    prev = 0;
    hold = 1'b0;
    for (int i = 0; i < nfr * N; i++) begin
      if (interior(i, W, H, K)) begin
        v = int'($urandom_range(0, 12)) - 6;
        inq.push_back(v);
        expq.push_back(quant(v, 0, WO));
      end else begin
        expq.push_back(0);
      end
    end
    total = (limit >= 0) ? limit : expq.size();
    while (k < total && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      valid_i = (inq.size() > 0) &&
                (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      data_i  = (inq.size() > 0) ? WI'(inq[0]) : '0;
      #1;
      if (hold) check("hold_data", int'(data_o), prev);
      if (valid_o && !ready_i) check("bp_ready", int'(ready_o), 0);
      if (valid_o && ready_i) begin
        check("pix", int'(data_o), expq[k]);
`ifdef CONV2D_REFRAME_MARKERS_EN
        check("sof", int'(sof), int'(k % N == 0));
        check("eol", int'(eol), int'(k % W == W - 1));
`endif
        k++;
      end
      if (valid_i && ready_o) void'(inq.pop_front());
      hold = valid_o && !ready_i;
      prev = int'(data_o);
    end
    check("run_done", k, total);
    if (limit < 0) check("inputs_used", inq.size(), 0);
    valid_i = 1'b0;
  endtask

  initial begin
    int acc, qa, qj;
    int qin[6];
    int qexp[6];
    int kin[20];
    qin  = '{7, -5, 100, 2, 0, 3};
    qexp = '{3, 0, 3, 1, 0, 1};
    for (int i = 0; i < 20; i++) kin[i] = int'($urandom_range(0, 8)) - 3;
    acc = 0;
    qa  = 0;
    qj  = 0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_ready", int'(ready_o), 0);
`ifdef CONV2D_REFRAME_MARKERS_EN
    check("rst_sof", int'(sof), 0);
    check("rst_eol", int'(eol), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 28; c++) begin
      valid_i   = (acc < 6);
      data_i    = WI'(1);
      q_valid_i = (qa < 6);
      q_data_i  = WI'(qin[qa < 6 ? qa : 0]);
      k_valid_i = (c < 20);
      k_data_i  = WI'(kin[c < 20 ? c : 0]);
      #1;
      check("t1_ready", int'(ready_o),
            int'(interior(c < 26 ? c : 26, W, H, K)));
      if (c >= 1 && c <= 26) begin
        check("t1_valid", int'(valid_o), 1);
        check("t1_pix", int'(data_o), int'(interior(c - 1, W, H, K)));
`ifdef CONV2D_REFRAME_MARKERS_EN
        check("t1_sof", int'(sof), int'((c - 1) % N == 0));
        check("t1_eol", int'(eol), int'((c - 1) % W == W - 1));
`endif
      end
      if (c == 27) check("t1_stall", int'(valid_o), 0);
      if (valid_i && ready_o) acc++;

      if (c >= 1 && c <= 20) begin
        check("q_valid", int'(q_valid_o), 1);
        if (interior(c - 1, W, H, K)) begin
          check("q_pix", int'(q_data_o), qexp[qj]);
          qj++;
        end else begin
          check("q_fill", int'(q_data_o), 0);
        end
      end
      if (q_valid_i && q_ready_o) qa++;

      if (c < 20) check("k1_ready", int'(k_ready_o), 1);
      if (c >= 1 && c <= 20) begin
        check("k1_valid", int'(k_valid_o), 1);
        check("k1_pix", int'(k_data_o), quant(kin[c - 1], 0, WO));
      end
      @(negedge clk);
    end
    check("t1_inputs", acc, 6);
    check("q_inputs", qa, 6);

    rst_n     = 1'b0;
    valid_i   = 1'b0;
    q_valid_i = 1'b0;
    k_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1'b0, 9);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(valid_o), 0);
    check("async_rst_data", int'(data_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 1'b0, -1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
